// File: rtl/opb_register_simulink2ppc.sv
// OPB read-back register: captures a fabric word with a valid strobe and serves it to the PPC.
// Optional capture counter enabled with `define CAPTURE_COUNT_EN.
module opb_register_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h01080100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010801FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [31:0]               user_data_in,
    input  logic                      user_valid,
    output logic                      user_frozen
);

    localparam int AW = C_OPB_AWIDTH;
    localparam unused_family = C_FAMILY;

    typedef enum logic {
        IDLE,
        ACK
    } bus_state_t;

    bus_state_t  state_q;
    bus_state_t  state_d;
    logic [7:0]  offset;
    logic [7:0]  off_q;
    logic        rnw_q;
    logic        hit;
    logic [31:0] rd_word;
    logic [31:0] data_q;
    logic        new_q;
    logic        ovr_q;
    logic        frz_q;
    logic [31:0] count_rd;
    logic        ack_end;
    logic        wr_en;
    logic        wr_status;
    logic        wr_ctrl;
    logic        rd_data_ack;
    logic        capture;
    logic        ovr_event;
    logic        unused_ok;

    assign offset = OPB_ABus[AW-8:AW-1];
    assign hit    = OPB_select
                 && (OPB_ABus >= C_BASEADDR)
                 && (OPB_ABus <= C_HIGHADDR);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (hit && !Sl_xferAck) state_d = ACK;
            ACK:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    assign Sl_xferAck = (state_q == ACK);
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Bus-side effects land at the edge that ends the ack cycle.
    assign ack_end     = (state_q == ACK);
    assign wr_en       = ack_end && !rnw_q;
    assign wr_status   = wr_en && (off_q == 8'h04) && OPB_BE[3] && OPB_DBus[30];
    assign wr_ctrl     = wr_en && (off_q == 8'h08) && OPB_BE[3];
    assign rd_data_ack = ack_end && rnw_q && (off_q == 8'h00);

    assign capture   = user_valid && !frz_q;
    assign ovr_event = user_valid && (frz_q || new_q);

    always_comb begin
        rd_word = '0;
        case (offset)
            8'h00:   rd_word = data_q;
            8'h04:   rd_word = {30'd0, ovr_q, new_q};
            8'h08:   rd_word = {31'd0, frz_q};
            8'h0C:   rd_word = count_rd;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            Sl_DBus <= '0;
            off_q   <= '0;
            rnw_q   <= 1'b0;
        end else begin
            Sl_DBus <= (state_d == ACK && OPB_RNW) ? rd_word : '0;
            if (state_d == ACK) begin
                off_q <= offset;
                rnw_q <= OPB_RNW;
            end
        end
    end

    // Capture beats the read-clear of NEW; an overrun beats its clear.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_q <= '0;
            new_q  <= 1'b0;
            ovr_q  <= 1'b0;
            frz_q  <= 1'b0;
        end else begin
            if (capture) data_q <= user_data_in;
            if (capture)          new_q <= 1'b1;
            else if (rd_data_ack) new_q <= 1'b0;
            if (ovr_event)      ovr_q <= 1'b1;
            else if (wr_status) ovr_q <= 1'b0;
            if (wr_ctrl) frz_q <= OPB_DBus[31];
        end
    end

`ifdef CAPTURE_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst)      count_q <= '0;
        else if (capture) count_q <= count_q + 32'd1;
    end

    assign count_rd = count_q;
`else
    assign count_rd = '0;
`endif

    assign user_frozen = frz_q;
    assign unused_ok   = ^{OPB_seqAddr, OPB_DBus[0:29], OPB_BE[0:2]};

endmodule
